// File: rtl/udp_tx_arbiter.sv
// Two-port round-robin arbiter feeding one UDP TX header+payload stream.
// A frame owner keeps the grant from header accept through the tlast beat.
module udp_tx_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [2*112-1:0]        s_hdr_data,
    input  logic [1:0]              s_hdr_valid,
    output logic [1:0]              s_hdr_ready,
    input  logic [2*DATA_WIDTH-1:0] s_payload_tdata,
    input  logic [2*KEEP_WIDTH-1:0] s_payload_tkeep,
    input  logic [1:0]              s_payload_tvalid,
    input  logic [1:0]              s_payload_tlast,
    input  logic [1:0]              s_payload_tuser,
    output logic [1:0]              s_payload_tready,
    output logic [111:0]            m_hdr_data,
    output logic                    m_hdr_valid,
    input  logic                    m_hdr_ready,
    output logic [DATA_WIDTH-1:0]   m_payload_tdata,
    output logic [KEEP_WIDTH-1:0]   m_payload_tkeep,
    output logic                    m_payload_tvalid,
    output logic                    m_payload_tlast,
    output logic                    m_payload_tuser,
    input  logic                    m_payload_tready,
    output logic [1:0]              grant,
    output logic                    len_err
);
    localparam int HDR_WIDTH = 112;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t      state;
    logic        rr_pri;       // 1: port 1 wins a tie
    logic [15:0] length;
    logic [15:0] byte_cnt;

    logic        gidx;
    logic        in_hdr;
    logic        in_pay;
    logic        win1;
    logic        hdr_fire;
    logic        beat_fire;
    logic [15:0] beat_bytes;
    logic [16:0] sum_raw;
    logic [15:0] sum_sat;
    logic        len_bad;

    function automatic logic [15:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) c = c + {15'd0, k[i]};
        return c;
    endfunction

    assign gidx   = grant[1];
    assign in_hdr = (state == HDR);
    assign in_pay = (state == PAYLOAD);
    assign win1   = s_hdr_valid[1] && (!s_hdr_valid[0] || rr_pri);

    assign m_hdr_data  = gidx ? s_hdr_data[2*HDR_WIDTH-1:HDR_WIDTH] : s_hdr_data[HDR_WIDTH-1:0];
    assign m_hdr_valid = in_hdr && (gidx ? s_hdr_valid[1] : s_hdr_valid[0]);
    assign s_hdr_ready = in_hdr ? (grant & {2{m_hdr_ready}}) : 2'b00;

    assign m_payload_tdata  = gidx ? s_payload_tdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : s_payload_tdata[DATA_WIDTH-1:0];
    assign m_payload_tkeep  = gidx ? s_payload_tkeep[2*KEEP_WIDTH-1:KEEP_WIDTH]
                                   : s_payload_tkeep[KEEP_WIDTH-1:0];
    assign m_payload_tvalid = in_pay && (gidx ? s_payload_tvalid[1] : s_payload_tvalid[0]);
    assign m_payload_tlast  = gidx ? s_payload_tlast[1] : s_payload_tlast[0];
    assign m_payload_tuser  = gidx ? s_payload_tuser[1] : s_payload_tuser[0];
    assign s_payload_tready = in_pay ? (grant & {2{m_payload_tready}}) : 2'b00;

    assign hdr_fire   = m_hdr_valid && m_hdr_ready;
    assign beat_fire  = m_payload_tvalid && m_payload_tready;
    assign beat_bytes = popcnt(m_payload_tkeep);
    assign sum_raw    = {1'b0, byte_cnt} + {1'b0, beat_bytes};
    assign sum_sat    = sum_raw[16] ? 16'hFFFF : sum_raw[15:0];
    // length - 8 wraps for short lengths, so those are flagged explicitly
    assign len_bad    = (length < 16'd8) || (sum_sat != length - 16'd8);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            grant    <= 2'b00;
            rr_pri   <= 1'b0;
            length   <= '0;
            byte_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|s_hdr_valid) begin
                        grant <= win1 ? 2'b10 : 2'b01;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_fire) begin
                        length   <= m_hdr_data[111:96];
                        byte_cnt <= '0;
                        state    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (beat_fire) begin
                        byte_cnt <= sum_sat;
                        if (m_payload_tlast) begin
                            len_err <= len_bad;
                            rr_pri  <= ~gidx;
                            grant   <= 2'b00;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: framing, round-robin, length check, reset.
module tb_udp_tx_arbiter;
    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [223:0]   s_hdr_data = '0;
    logic [1:0]     s_hdr_valid = '0;
    logic [1:0]     s_hdr_ready;
    logic [127:0]   s_payload_tdata = '0;
    logic [15:0]    s_payload_tkeep = '0;
    logic [1:0]     s_payload_tvalid = '0;
    logic [1:0]     s_payload_tlast = '0;
    logic [1:0]     s_payload_tuser = '0;
    logic [1:0]     s_payload_tready;
    logic [111:0]   m_hdr_data;
    logic           m_hdr_valid;
    logic           m_hdr_ready = 1'b0;
    logic [63:0]    m_payload_tdata;
    logic [7:0]     m_payload_tkeep;
    logic           m_payload_tvalid;
    logic           m_payload_tlast;
    logic           m_payload_tuser;
    logic           m_payload_tready = 1'b0;
    logic [1:0]     grant;
    logic           len_err;

    int checks = 0;
    int errors = 0;
    int acc_beats = 0;
    int exp_beats = 0;

    udp_tx_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_hdr_data(s_hdr_data), .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_payload_tdata(s_payload_tdata), .s_payload_tkeep(s_payload_tkeep),
        .s_payload_tvalid(s_payload_tvalid), .s_payload_tlast(s_payload_tlast),
        .s_payload_tuser(s_payload_tuser), .s_payload_tready(s_payload_tready),
        .m_hdr_data(m_hdr_data), .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
        .m_payload_tdata(m_payload_tdata), .m_payload_tkeep(m_payload_tkeep),
        .m_payload_tvalid(m_payload_tvalid), .m_payload_tlast(m_payload_tlast),
        .m_payload_tuser(m_payload_tuser), .m_payload_tready(m_payload_tready),
        .grant(grant), .len_err(len_err)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk)
        if (aresetn && m_payload_tvalid && m_payload_tready) acc_beats <= acc_beats + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [111:0] hdr_of(input int p, input logic [15:0] len);
        return {len, 16'(16'h1000 + p), 16'(16'h2000 + p),
                32'(32'h0a000001 + p), 32'(32'hc0a80001 + p)};
    endfunction

    function automatic logic [63:0] dat_of(input int p, input int i);
        return {8'(8'hD0 + p), 8'(i), 48'h5A5A_1234_00C3};
    endfunction

    task automatic set_hdr(input int p, input logic [15:0] len);
        s_hdr_data[p*112 +: 112] = hdr_of(p, len);
        s_hdr_valid[p] = 1'b1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        @(posedge aclk); @(posedge aclk); #1;
        aresetn = 1'b1;
    endtask

    task automatic wait_grant(input logic [1:0] gexp);
        int k;
        k = 0;
        while (grant !== gexp && k < 40) begin
            @(posedge aclk); #1;
            k++;
        end
        chk("grant", grant, gexp);
    endtask

    // Runs one complete frame on port p; lkeep is the keep of the final beat.
    task automatic send_frame(input int p, input logic [15:0] len, input int nb,
                              input logic [7:0] lkeep, input bit rnd, input bit exp_err);
        logic [1:0] gexp;
        logic [7:0] keep;
        bit acc;
        int k;
        gexp = 2'(1 << p);
        set_hdr(p, len);
        m_hdr_ready = 1'b1;
        wait_grant(gexp);
        chk("hdr_valid", m_hdr_valid, 1'b1);
        chk("hdr_data", m_hdr_data, hdr_of(p, len));
        chk("hdr_ready", s_hdr_ready, gexp);
        chk("pay_valid_hdr", m_payload_tvalid, 1'b0);
        @(posedge aclk); #1;
        s_hdr_valid[p] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            keep = (i == nb - 1) ? lkeep : 8'hFF;
            s_payload_tdata[p*64 +: 64] = dat_of(p, i);
            s_payload_tkeep[p*8 +: 8] = keep;
            s_payload_tlast[p] = (i == nb - 1);
            s_payload_tuser[p] = i[0];
            s_payload_tvalid[p] = 1'b1;
            acc = 1'b0;
            k = 0;
            while (!acc && k < 100) begin
                m_payload_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                chk("pay_valid", m_payload_tvalid, 1'b1);
                chk("pay_data", m_payload_tdata, dat_of(p, i));
                chk("pay_keep", m_payload_tkeep, keep);
                chk("pay_last", m_payload_tlast, (i == nb - 1));
                chk("pay_user", m_payload_tuser, i[0]);
                chk("pay_ready", s_payload_tready, m_payload_tready ? gexp : 2'b00);
                chk("hdr_ready_pay", s_hdr_ready, 2'b00);
                chk("hdr_valid_pay", m_hdr_valid, 1'b0);
                acc = m_payload_tready;
                @(posedge aclk); #1;
                k++;
            end
            if (!acc) chk("beat_timeout", 1'b0, 1'b1);
            exp_beats++;
        end
        s_payload_tvalid[p] = 1'b0;
        s_payload_tlast[p] = 1'b0;
        m_payload_tready = 1'b0;
        #1;
        chk("len_err", len_err, exp_err);
        chk("grant_end", grant, 2'b00);
        chk("pay_valid_end", m_payload_tvalid, 1'b0);
        @(posedge aclk); #1;
        chk("len_err_pulse", len_err, 1'b0);
    endtask

    initial begin
        @(posedge aclk); @(posedge aclk); #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_hdr_valid", m_hdr_valid, 1'b0);
        chk("rst_pay_valid", m_payload_tvalid, 1'b0);
        chk("rst_hdr_ready", s_hdr_ready, 2'b00);
        chk("rst_pay_ready", s_payload_tready, 2'b00);
        aresetn = 1'b1;

        // Single port, exact length: 24 - 8 = 16 bytes over two full beats
        set_hdr(0, 16'd24);
        m_hdr_ready = 1'b1;
        #1;
        chk("idle_hdr_ready", s_hdr_ready, 2'b00);
        send_frame(0, 16'd24, 2, 8'hFF, 1'b0, 1'b0);

        // Short last beat: 8 + 4 = 12 bytes against 16 expected
        send_frame(0, 16'd24, 2, 8'h0F, 1'b0, 1'b1);
        // length below 8 always flags; length 8 with zero bytes is exact
        send_frame(1, 16'd4, 1, 8'h00, 1'b0, 1'b1);
        send_frame(1, 16'd8, 1, 8'h00, 1'b0, 1'b0);

        // Contention from reset: port 0 first, port 1 held through a 10-beat frame
        do_reset();
        set_hdr(0, 16'd88);
        set_hdr(1, 16'd16);
        @(posedge aclk); #1;
        chk("rr_first", grant, 2'b01);
        send_frame(0, 16'd88, 10, 8'hFF, 1'b0, 1'b0);
        chk("rr_second", grant, 2'b10);
        send_frame(1, 16'd16, 1, 8'hFF, 1'b0, 1'b0);
        set_hdr(0, 16'd16);
        set_hdr(1, 16'd16);
        @(posedge aclk); #1;
        chk("rr_third", grant, 2'b01);
        send_frame(0, 16'd16, 1, 8'hFF, 1'b0, 1'b0);
        chk("rr_fourth", grant, 2'b10);
        send_frame(1, 16'd16, 1, 8'hFF, 1'b0, 1'b0);

        // Backpressured frame on port 1
        send_frame(1, 16'd48, 5, 8'hFF, 1'b1, 1'b0);

        // Reset on the first payload beat abandons the frame silently
        set_hdr(0, 16'd24);
        m_hdr_ready = 1'b1;
        wait_grant(2'b01);
        @(posedge aclk); #1;
        s_hdr_valid[0] = 1'b0;
        s_payload_tdata[63:0] = dat_of(0, 0);
        s_payload_tkeep[7:0] = 8'hFF;
        s_payload_tvalid[0] = 1'b1;
        m_payload_tready = 1'b1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        s_payload_tvalid[0] = 1'b0;
        m_payload_tready = 1'b0;
        chk("mid_rst_grant", grant, 2'b00);
        chk("mid_rst_len_err", len_err, 1'b0);
        chk("mid_rst_pay_valid", m_payload_tvalid, 1'b0);
        @(posedge aclk); #1;
        chk("mid_rst_len_err2", len_err, 1'b0);
        send_frame(1, 16'd16, 1, 8'hFF, 1'b0, 1'b0);
        send_frame(0, 16'd12, 1, 8'h0F, 1'b0, 1'b0);

        @(posedge aclk); #1;
        chk("beat_count", acc_beats, exp_beats);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
